wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Captures register write-back events retired by the multicycle RISC-V core and buffers them in a FIFO for a downstream consumer (testbench monitor, debug UART, checker). Sits directly downstream of the core datapath: it samples the write strobe, destination register, write data and PC at each write-back, tags each event with a sequence number and exposes it on a valid/ready drain port. Drops and occupancy are counted so the consumer can detect lost events.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- SEQ_W, 16, sequence-number width
- DROP_W, 16, drop-counter width (saturating)

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- wb_en  in  1  write-back strobe; one event per high cycle
- wb_rd  in  5  destination register index
- wb_data  in  64  value written to the register bank
- wb_pc  in  64  PC of the instruction performing the write
- flush  in  1  empty the FIFO (synchronous)
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_seq  out  SEQ_W  sequence number of head entry
- out_pc  out  64  PC of head entry
- out_rd  out  5  rd of head entry
- out_data  out  64  data of head entry
- count  out  log2(DEPTH)+1  current occupancy
- drop_cnt  out  DROP_W  events lost to full FIFO
- full  out  1  count == DEPTH

## Operation
- Qualifying event: wb_en=1 and wb_rd≠0. Writes to x0 are ignored entirely (no push, no seq increment, no drop).
- seq counter: increments by 1 (mod 2^SEQ_W) on every qualifying event, stored or dropped; stored entry carries the pre-increment value. Gaps in out_seq therefore reveal drops.
- Push: qualifying event and (not full, or pop in same cycle). Entry {seq, wb_pc, wb_rd, wb_data} written at tail; tail pointer wraps mod DEPTH.
- Pop: out_valid & out_ready; head pointer advances mod DEPTH.
- Drop: qualifying event while full and no pop in that cycle; entry discarded, drop_cnt += 1, saturating at all-ones (never wraps).
- Simultaneous push+pop: both take effect, count unchanged; valid when full (freed slot reused) and when count=1.
- Push into empty with out_ready=1: no bypass; pop is impossible in that cycle (out_valid=0).
- flush: head, tail, count cleared to 0; overrides any push/pop in the same cycle (an event coincident with flush is not stored and not counted as drop, but seq still increments). seq and drop_cnt keep their values.
- out_seq/out_pc/out_rd/out_data: head entry when out_valid=1; forced to 0 when out_valid=0.
- Storage array needs no reset; pointers/counters do.

## Timing
- Reset (reset=1 at rising edge): count=0, out_valid=0, full=0, drop_cnt=0, seq=0, all out_* fields 0, from the cycle after the edge. Reset mid-burst discards all buffered entries.
- Latency: event sampled at edge N appears on out_* with out_valid=1 after edge N (visible in cycle N+1) if FIFO was empty.
- out_valid, count, full are registered-state derived; out_* are combinational reads of the head entry (no extra pipeline stage).
- Handshake: once out_valid=1, head entry and out_valid hold stable until popped, flushed or reset; consumer may hold out_ready high continuously for 1 entry/cycle throughput.
- count and drop_cnt update on the same edge as the push/pop/drop that changes them.

## Test plan
- Reset then three events (rd=5,data=0x11,pc=0x0; rd=6,0x22,0x4; rd=7,0x33,0x8) with out_ready=0 -> count=3, head shows seq=0,rd=5,data=0x11,pc=0x0; drain with out_ready=1 -> seq 0,1,2 in order, count returns 0, out_valid=0, out_* =0.
- Event with wb_rd=0 between two rd=1 events -> only two entries stored, out_seq 0 then 1, drop_cnt=0.
- DEPTH+3 events with out_ready=0 -> full=1, count=DEPTH, drop_cnt=3; drain yields seq 0..DEPTH-1; next stored event gets seq DEPTH+3.
- Full FIFO, out_ready=1 and wb_en=1 same cycle -> count stays DEPTH, drop_cnt unchanged, new entry appears last; continuous push+pop for 2*DEPTH cycles exercises pointer wrap with no loss.
- 5 entries buffered, flush=1 coincident with event and out_ready=1 -> count=0, out_valid=0 next cycle, drop_cnt unchanged, next event carries seq=6.
- Force 2^DROP_W+2 drops (small DROP_W build, e.g. 4) -> drop_cnt saturates at 0xF; reset mid-stream -> count, seq, drop_cnt all 0 next cycle.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: captures retired register writes with a sequence tag
// and presents them on a valid/ready drain port. It also counts drops and reports occupancy.
module wb_trace_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SEQ_W  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_en,
  input  logic [4:0]                 wb_rd,
  input  logic [63:0]                wb_data,
  input  logic [63:0]                wb_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [63:0]                out_pc,
  output logic [4:0]                 out_rd,
  output logic [63:0]                out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Handshake: an entry transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and the
  // head entry holds stable while out_valid=1 until it is popped, flushed or reset.

  logic [SEQ_W-1:0] memSeq  [DEPTH];
  logic [63:0]      memPc   [DEPTH];
  logic [4:0]       memRd   [DEPTH];
  logic [63:0]      memData [DEPTH];

  logic [AW-1:0]     headPtr, tailPtr;
  logic [AW:0]       occ;
  logic [SEQ_W-1:0]  seqCnt;
  logic [DROP_W-1:0] dropCnt;

  logic qualify, isFull, hasData, popEn, pushEn, dropEn;

  always_comb begin
    qualify = wb_en && (wb_rd != 5'd0);
    isFull  = (occ == FULL_CNT);
    hasData = (occ != '0);
    popEn   = hasData && out_ready;
    // A pop in the same cycle frees the slot the incoming event needs.
    pushEn  = qualify && (!isFull || popEn);
    dropEn  = qualify && isFull && !popEn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      occ     <= '0;
      seqCnt  <= '0;
      dropCnt <= '0;
    end else if (flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      occ     <= '0;
      if (qualify) seqCnt <= seqCnt + SEQ_W'(1);
    end else begin
      if (qualify) seqCnt <= seqCnt + SEQ_W'(1);
      if (pushEn)  tailPtr <= tailPtr + AW'(1);
      if (popEn)   headPtr <= headPtr + AW'(1);
      case ({pushEn, popEn})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (dropEn && (dropCnt != '1)) dropCnt <= dropCnt + DROP_W'(1);
    end
  end

  // Storage is not reset; entries are only visible once the pointers cover them.
  always_ff @(posedge clk) begin
    if (pushEn && !flush && !reset) begin
      memSeq[tailPtr]  <= seqCnt;
      memPc[tailPtr]   <= wb_pc;
      memRd[tailPtr]   <= wb_rd;
      memData[tailPtr] <= wb_data;
    end
  end

  always_comb begin
    out_valid = hasData;
    count     = occ;
    full      = isFull;
    drop_cnt  = dropCnt;
    out_seq   = '0;
    out_pc    = '0;
    out_rd    = '0;
    out_data  = '0;
    if (hasData) begin
      out_seq  = memSeq[headPtr];
      out_pc   = memPc[headPtr];
      out_rd   = memRd[headPtr];
      out_data = memData[headPtr];
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the trace buffer.
module tb_wb_trace_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned DROP_W = 4;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic              clk = 1'b0;
  logic              reset, wb_en, flush, out_ready;
  logic [4:0]        wb_rd;
  logic [63:0]       wb_data, wb_pc;
  logic              out_valid, full;
  logic [SEQ_W-1:0]  out_seq;
  logic [63:0]       out_pc, out_data;
  logic [4:0]        out_rd;
  logic [4:0]        count;
  logic [DROP_W-1:0] drop_cnt;

  wb_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_seq(out_seq), .out_pc(out_pc), .out_rd(out_rd), .out_data(out_data),
    .count(count), .drop_cnt(drop_cnt), .full(full)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard / model
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [63:0]      pc;
    logic [4:0]       rd;
    logic [63:0]      data;
  } entry_t;

  entry_t            expQ[$];
  logic [SEQ_W-1:0]  mSeq;
  logic [DROP_W-1:0] mDrop;
  bit                started = 1'b0;
  int                totalChecks = 0;
  int                passChecks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalChecks++;
    if (act === exp) passChecks++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      expQ.delete();
      mSeq    = '0;
      mDrop   = '0;
      started = 1'b1;
    end else if (started) begin
      if (flush) begin
        expQ.delete();
        if (wb_en && wb_rd != 0) mSeq = mSeq + 1'b1;
      end else begin
        if (expQ.size() > 0 && out_ready) void'(expQ.pop_front());
        if (wb_en && wb_rd != 0) begin
          if (expQ.size() < DEPTH) expQ.push_back('{seq: mSeq, pc: wb_pc, rd: wb_rd, data: wb_data});
          else if (mDrop != DROP_MAX) mDrop = mDrop + 1'b1;
          mSeq = mSeq + 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(expQ.size() > 0));
      check("count", 64'(count), 64'(expQ.size()));
      check("full", 64'(full), 64'(expQ.size() == DEPTH));
      check("drop_cnt", 64'(drop_cnt), 64'(mDrop));
      if (expQ.size() > 0) begin
        check("out_seq", 64'(out_seq), 64'(expQ[0].seq));
        check("out_pc", out_pc, expQ[0].pc);
        check("out_rd", 64'(out_rd), 64'(expQ[0].rd));
        check("out_data", out_data, expQ[0].data);
      end else begin
        check("idle_fields", {out_seq, out_rd, 43'd0} | out_pc | out_data, 64'd0);
      end
    end
  end

  // Driver tasks
  task automatic step(input logic en, input logic [4:0] rd, input logic [63:0] d,
                      input logic [63:0] pc, input logic rdy, input logic fl, input logic rst);
    wb_en = en; wb_rd = rd; wb_data = d; wb_pc = pc;
    out_ready = rdy; flush = fl; reset = rst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_n(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      step(1'b1, 5'(1 + (i % 31)), 64'(32'h1000 + i), 64'(4 * i), rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 5'd0, 64'd0, 64'd0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    wb_en = 0; wb_rd = 0; wb_data = 0; wb_pc = 0; out_ready = 0; flush = 0; reset = 1;
    @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);

    // Three events, then drain in order
    step(1'b1, 5'd5, 64'h11, 64'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd6, 64'h22, 64'h4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd7, 64'h33, 64'h8, 1'b0, 1'b0, 1'b0);
    check("t1_count", 64'(count), 64'd3);
    check("t1_head_seq", 64'(out_seq), 64'd0);
    check("t1_head_rd", 64'(out_rd), 64'd5);
    check("t1_head_data", out_data, 64'h11);
    check("t1_head_pc", out_pc, 64'h0);
    for (int i = 0; i < 3; i++) begin
      check("t1_drain_seq", 64'(out_seq), 64'(i));
      idle(1'b1);
    end
    check("t1_empty_count", 64'(count), 64'd0);
    check("t1_empty_valid", 64'(out_valid), 64'd0);
    check("t1_empty_data", out_data, 64'd0);

    // x0 writes are invisible
    do_reset();
    step(1'b1, 5'd1, 64'hA, 64'h10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 64'hB, 64'h14, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd1, 64'hC, 64'h18, 1'b0, 1'b0, 1'b0);
    check("t2_count", 64'(count), 64'd2);
    check("t2_seq0", 64'(out_seq), 64'd0);
    idle(1'b1);
    check("t2_seq1", 64'(out_seq), 64'd1);
    check("t2_data1", out_data, 64'hC);
    check("t2_drop", 64'(drop_cnt), 64'd0);

    // Overflow: DEPTH+3 events
    do_reset();
    push_n(DEPTH + 3, 1'b0);
    check("t3_full", 64'(full), 64'd1);
    check("t3_count", 64'(count), 64'(DEPTH));
    check("t3_drop", 64'(drop_cnt), 64'd3);
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_drain_seq", 64'(out_seq), 64'(i));
      idle(1'b1);
    end
    step(1'b1, 5'd3, 64'h55, 64'h80, 1'b0, 1'b0, 1'b0);
    check("t3_next_seq", 64'(out_seq), 64'(DEPTH + 3));

    // Push+pop on a full FIFO, then streaming through pointer wrap
    do_reset();
    push_n(DEPTH, 1'b0);
    step(1'b1, 5'd9, 64'h99, 64'h200, 1'b1, 1'b0, 1'b0);
    check("t4_count", 64'(count), 64'(DEPTH));
    check("t4_drop", 64'(drop_cnt), 64'd0);
    check("t4_head_seq", 64'(out_seq), 64'd1);
    push_n(2 * DEPTH, 1'b1);
    check("t4_wrap_count", 64'(count), 64'(DEPTH));
    check("t4_wrap_seq", 64'(out_seq), 64'(2 * DEPTH + 1));
    check("t4_wrap_drop", 64'(drop_cnt), 64'd0);

    // Flush coincident with an event and a pop
    do_reset();
    push_n(5, 1'b0);
    step(1'b1, 5'd2, 64'h77, 64'h300, 1'b1, 1'b1, 1'b0);
    check("t5_count", 64'(count), 64'd0);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_drop", 64'(drop_cnt), 64'd0);
    step(1'b1, 5'd2, 64'h78, 64'h304, 1'b0, 1'b0, 1'b0);
    check("t5_next_seq", 64'(out_seq), 64'd6);

    // Drop counter saturation, then reset mid-stream
    do_reset();
    push_n(DEPTH + (1 << DROP_W) + 2, 1'b0);
    check("t6_drop_sat", 64'(drop_cnt), 64'hF);
    step(1'b1, 5'd4, 64'h1, 64'h0, 1'b0, 1'b0, 1'b1);
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_drop", 64'(drop_cnt), 64'd0);
    step(1'b1, 5'd4, 64'h2, 64'h4, 1'b0, 1'b0, 1'b0);
    check("t6_rst_seq", 64'(out_seq), 64'd0);

    // Random traffic with shifting consumer pressure
    for (int blk = 0; blk < 6; blk++) begin
      int rdyPct;
      rdyPct = $urandom_range(10, 95);
      for (int i = 0; i < 500; i++) begin
        step(1'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 31)),
             {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 99) < rdyPct),
             1'($urandom_range(0, 99) == 0),
             1'($urandom_range(0, 399) == 0));
      end
    end
    idle(1'b0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
